arm_shift_seq: RTL and testbench

Multi-cycle sequencer for the ARM operand-2 barrel shifter in the `arm/cpu` core. It accepts a shift request with either an immediate or a register-specified amount. For register amounts it fetches the amount from the register file. It then walks the 16/8/4/2/1 shift stages one per cycle and produces the shifted operand plus shifter carry-out using ARM semantics. It sits between instruction decode and the ALU operand-2 input.

---
 rtl/arm_shift_seq_if.sv | 28 ++
 rtl/arm_shift_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_arm_shift_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/arm_shift_seq_if.sv
// Handshake and register-file signals between decode, the operand-2 shift
// sequencer and the register file read port.
interface arm_shift_seq_if;
    logic        start;
    logic [31:0] op;
    logic [1:0]  stype;
    logic        use_reg;
    logic [4:0]  imm;
    logic [3:0]  rs;
    logic        c_in;
    logic [3:0]  rf_addr;
    logic        rf_rd;
    logic [31:0] rf_data;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        c_out;

    modport master (
        output start, op, stype, use_reg, imm, rs, c_in, rf_data,
        input  rf_addr, rf_rd, busy, done, result, c_out
    );

    modport slave (
        input  start, op, stype, use_reg, imm, rs, c_in, rf_data,
        output rf_addr, rf_rd, busy, done, result, c_out
    );
endinterface

// File: rtl/arm_shift_seq.sv
// Multi-cycle ARM operand-2 shift sequencer (16/8/4/2/1 stages, one per cycle).
// Optional ROR/RRX datapath enabled by defining ARM_SHIFT_ROR_EN.
module arm_shift_seq (
    input  logic            clock,
    input  logic            reset,
    arm_shift_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RDREG = 3'd1,
        S_LATCH = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] op_r;
    logic [31:0] val_r;
    logic [1:0]  stype_r;
    logic        cin_r;
    logic        carry_r;
    logic        usereg_r;
    logic [7:0]  amt_r;
    logic [2:0]  cnt_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] result_r;
    logic        c_out_r;
    logic        rf_rd_r;
    logic [3:0]  rf_addr_r;

    logic [4:0]  sh_s;
    logic        stage_en_s;
    logic [31:0] stage_val_s;
    logic        stage_c_s;
    logic [31:0] fin_res_s;
    logic        fin_c_s;

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.result  = result_r;
    assign bus.c_out   = c_out_r;
    assign bus.rf_rd   = rf_rd_r;
    assign bus.rf_addr = rf_addr_r;

    // One shift stage of 2^cnt; 0 - sh wraps to 32 - sh for the LSL carry tap.
    always_comb begin
        sh_s        = 5'd1 << cnt_r;
        stage_val_s = val_r;
        stage_c_s   = carry_r;
`ifdef ARM_SHIFT_ROR_EN
        stage_en_s  = amt_r[cnt_r] && ((amt_r[7:5] == 3'b000) || (stype_r == 2'b11));
`else
        stage_en_s  = amt_r[cnt_r] && (amt_r[7:5] == 3'b000);
`endif
        if (stage_en_s) begin
            case (stype_r)
                2'b00: begin
                    stage_val_s = val_r << sh_s;
                    stage_c_s   = val_r[5'd0 - sh_s];
                end
                2'b01: begin
                    stage_val_s = val_r >> sh_s;
                    stage_c_s   = val_r[sh_s - 5'd1];
                end
                2'b10: begin
                    stage_val_s = $signed(val_r) >>> sh_s;
                    stage_c_s   = val_r[sh_s - 5'd1];
                end
`ifdef ARM_SHIFT_ROR_EN
                2'b11: begin
                    stage_val_s = (val_r >> sh_s) | (val_r << (5'd0 - sh_s));
                    stage_c_s   = val_r[sh_s - 5'd1];
                end
`endif
                default: begin
                    stage_val_s = val_r;
                    stage_c_s   = carry_r;
                end
            endcase
        end else begin
            stage_val_s = val_r;
            stage_c_s   = carry_r;
        end
    end

    // ARM special encodings and out-of-range amounts applied on the last stage.
    always_comb begin
        fin_res_s = stage_val_s;
        fin_c_s   = stage_c_s;
        if (!usereg_r && (amt_r == 8'd0)) begin
            case (stype_r)
                2'b00:   begin fin_res_s = op_r;             fin_c_s = cin_r;    end
                2'b01:   begin fin_res_s = 32'd0;            fin_c_s = op_r[31]; end
                2'b10:   begin fin_res_s = {32{op_r[31]}};   fin_c_s = op_r[31]; end
`ifdef ARM_SHIFT_ROR_EN
                2'b11:   begin fin_res_s = {cin_r, op_r[31:1]}; fin_c_s = op_r[0]; end
`endif
                default: begin fin_res_s = op_r;             fin_c_s = cin_r;    end
            endcase
        end else if (amt_r == 8'd0) begin
            fin_res_s = op_r;
            fin_c_s   = cin_r;
        end else begin
            case (stype_r)
                2'b00: begin
                    if (amt_r == 8'd32) begin
                        fin_res_s = 32'd0; fin_c_s = op_r[0];
                    end else if (amt_r > 8'd32) begin
                        fin_res_s = 32'd0; fin_c_s = 1'b0;
                    end else begin
                        fin_res_s = stage_val_s; fin_c_s = stage_c_s;
                    end
                end
                2'b01: begin
                    if (amt_r == 8'd32) begin
                        fin_res_s = 32'd0; fin_c_s = op_r[31];
                    end else if (amt_r > 8'd32) begin
                        fin_res_s = 32'd0; fin_c_s = 1'b0;
                    end else begin
                        fin_res_s = stage_val_s; fin_c_s = stage_c_s;
                    end
                end
                2'b10: begin
                    if (amt_r >= 8'd32) begin
                        fin_res_s = {32{op_r[31]}}; fin_c_s = op_r[31];
                    end else begin
                        fin_res_s = stage_val_s; fin_c_s = stage_c_s;
                    end
                end
`ifdef ARM_SHIFT_ROR_EN
                2'b11: begin
                    if (amt_r[4:0] == 5'd0) begin
                        fin_res_s = op_r; fin_c_s = op_r[31];
                    end else begin
                        fin_res_s = stage_val_s; fin_c_s = stage_val_s[31];
                    end
                end
`endif
                default: begin
                    fin_res_s = op_r;
                    fin_c_s   = cin_r;
                end
            endcase
        end
    end

    // Sequencer state, datapath registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= S_IDLE;
            op_r      <= 32'd0;
            val_r     <= 32'd0;
            stype_r   <= 2'b00;
            cin_r     <= 1'b0;
            carry_r   <= 1'b0;
            usereg_r  <= 1'b0;
            amt_r     <= 8'd0;
            cnt_r     <= 3'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= 32'd0;
            c_out_r   <= 1'b0;
            rf_rd_r   <= 1'b0;
            rf_addr_r <= 4'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        op_r     <= bus.op;
                        val_r    <= bus.op;
                        stype_r  <= bus.stype;
                        cin_r    <= bus.c_in;
                        carry_r  <= bus.c_in;
                        usereg_r <= bus.use_reg;
                        busy_r   <= 1'b1;
                        if (bus.use_reg) begin
                            rf_rd_r   <= 1'b1;
                            rf_addr_r <= bus.rs;
                            state_r   <= S_RDREG;
                        end else begin
                            amt_r   <= {3'b000, bus.imm};
                            cnt_r   <= 3'd4;
                            state_r <= S_SHIFT;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RDREG: begin
                    rf_rd_r <= 1'b0;
                    state_r <= S_LATCH;
                end
                S_LATCH: begin
                    amt_r   <= bus.rf_data[7:0];
                    cnt_r   <= 3'd4;
                    state_r <= S_SHIFT;
                end
                S_SHIFT: begin
                    val_r   <= stage_val_s;
                    carry_r <= stage_c_s;
                    if (cnt_r == 3'd0) begin
                        result_r <= fin_res_s;
                        c_out_r  <= fin_c_s;
                        done_r   <= 1'b1;
                        state_r  <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_arm_shift_seq.sv
// Self-checking bench for arm_shift_seq: directed cases, random requests against
// a bit-at-a-time shift model, handshake and mid-operation reset.
module tb_arm_shift_seq;
    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    arm_shift_seq_if bus ();

    arm_shift_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: shift one bit at a time, the carry being the last bit to fall out.
    function automatic logic [32:0] model(input logic [31:0] op, input logic [1:0] st,
                                          input logic ur, input logic [7:0] amt, input logic ci);
        logic [31:0] v;
        logic        c;
        v = op;
        c = ci;
        if (!ur && amt == 8'd0) begin
            case (st)
                2'b00:   return {ci, op};
                2'b01:   return {op[31], 32'h0};
                2'b10:   return {op[31], {32{op[31]}}};
`ifdef ARM_SHIFT_ROR_EN
                default: return {op[0], ci, op[31:1]};
`else
                default: return {ci, op};
`endif
            endcase
        end
        if (amt == 8'd0) return {ci, op};
        case (st)
            2'b00: for (int i = 0; i < int'(amt); i++) begin c = v[31]; v = {v[30:0], 1'b0}; end
            2'b01: for (int i = 0; i < int'(amt); i++) begin c = v[0]; v = {1'b0, v[31:1]}; end
            2'b10: for (int i = 0; i < int'(amt); i++) begin c = v[0]; v = {v[31], v[31:1]}; end
            default: begin
`ifdef ARM_SHIFT_ROR_EN
                if (amt[4:0] == 5'd0) return {op[31], op};
                for (int i = 0; i < int'(amt[4:0]); i++) v = {v[0], v[31:1]};
                c = v[31];
`else
                return {ci, op};
`endif
            end
        endcase
        return {c, v};
    endfunction

    // Issue one request in cycle 0 and follow it to done (bounded at 20 cycles).
    task automatic run_op(input logic [31:0] op, input logic [1:0] st, input logic ur,
                          input logic [4:0] im, input logic [3:0] r, input logic ci,
                          input logic [31:0] rfd,
                          output logic [31:0] res, output logic co, output int lat,
                          output int rdc, output logic [3:0] rda,
                          output logic bsy1, output logic baft);
        lat = -1; rdc = -1; rda = 4'd0; res = 32'd0; co = 1'b0;
        @(negedge clock);
        bus.start = 1'b1; bus.op = op; bus.stype = st; bus.use_reg = ur;
        bus.imm = im; bus.rs = r; bus.c_in = ci;
        @(negedge clock);
        bus.start = 1'b0; bus.op = $urandom; bus.c_in = 1'($urandom);
        bus.rs = 4'($urandom); bus.imm = 5'($urandom); bus.stype = 2'($urandom);
        bsy1 = bus.busy;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (bus.rf_rd === 1'b1 && rdc < 0) begin rdc = cyc; rda = bus.rf_addr; end
            bus.rf_data = (rdc >= 0 && cyc == rdc + 1) ? rfd : $urandom;
            if (bus.done === 1'b1) begin
                lat = cyc; res = bus.result; co = bus.c_out;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        baft = bus.busy;
    endtask

    logic [31:0] res;
    logic        co;
    int          lat, rdc, ndone;
    logic [3:0]  rda;
    logic        bsy1, baft, b7;
    logic [32:0] e;
    logic [31:0] op, rfd;
    logic [1:0]  st;
    logic        ur, ci;
    logic [4:0]  im;
    logic [3:0]  r;
    logic [7:0]  a;

    initial begin
        bus.start = 1'b0; bus.op = 32'd0; bus.stype = 2'b00; bus.use_reg = 1'b0;
        bus.imm = 5'd0; bus.rs = 4'd0; bus.c_in = 1'b0; bus.rf_data = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_done", bus.done, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_cout", bus.c_out, 32'd0);
        chk("rst_rfrd", bus.rf_rd, 32'd0);
        chk("rst_rfaddr", bus.rf_addr, 32'd0);
        reset = 1'b0;

        run_op(32'h80000001, 2'b00, 1'b0, 5'd1, 4'd0, 1'b0, 32'd0, res, co, lat, rdc, rda, bsy1, baft);
        chk("lsl1_lat", lat, 32'd6);
        chk("lsl1_res", res, 32'h00000002);
        chk("lsl1_c", co, 32'd1);
        chk("lsl1_busy1", bsy1, 32'd1);
        chk("lsl1_busy_after", baft, 32'd0);
        chk("imm_no_rfrd", rdc, 32'hFFFFFFFF);

        run_op(32'h80000000, 2'b01, 1'b0, 5'd0, 4'd0, 1'b0, 32'd0, res, co, lat, rdc, rda, bsy1, baft);
        chk("lsr0_res", res, 32'h0);
        chk("lsr0_c", co, 32'd1);
        run_op(32'h80000000, 2'b10, 1'b0, 5'd0, 4'd0, 1'b0, 32'd0, res, co, lat, rdc, rda, bsy1, baft);
        chk("asr0_res", res, 32'hFFFFFFFF);
        chk("asr0_c", co, 32'd1);

        run_op(32'hFFFFFFFF, 2'b00, 1'b1, 5'd0, 4'd3, 1'b0, 32'h21, res, co, lat, rdc, rda, bsy1, baft);
        chk("reg33_rdc", rdc, 32'd1);
        chk("reg33_rda", rda, 32'd3);
        chk("reg33_lat", lat, 32'd8);
        chk("reg33_res", res, 32'h0);
        chk("reg33_c", co, 32'd0);
        run_op(32'hFFFFFFFF, 2'b00, 1'b1, 5'd0, 4'd3, 1'b1, 32'h100, res, co, lat, rdc, rda, bsy1, baft);
        chk("reg256_res", res, 32'hFFFFFFFF);
        chk("reg256_c", co, 32'd1);

`ifdef ARM_SHIFT_ROR_EN
        run_op(32'h00000003, 2'b11, 1'b0, 5'd1, 4'd0, 1'b0, 32'd0, res, co, lat, rdc, rda, bsy1, baft);
        chk("ror1_res", res, 32'h80000001);
        chk("ror1_c", co, 32'd1);
        run_op(32'h00000002, 2'b11, 1'b0, 5'd0, 4'd0, 1'b1, 32'd0, res, co, lat, rdc, rda, bsy1, baft);
        chk("rrx_res", res, 32'h80000001);
        chk("rrx_c", co, 32'd0);
`else
        run_op(32'h00000003, 2'b11, 1'b0, 5'd1, 4'd0, 1'b1, 32'd0, res, co, lat, rdc, rda, bsy1, baft);
        chk("noror_res", res, 32'h00000003);
        chk("noror_c", co, 32'd1);
        chk("noror_lat", lat, 32'd6);
`endif

        for (int i = 0; i < 40; i++) begin
            op = $urandom; st = 2'($urandom_range(0, 3)); ur = 1'($urandom_range(0, 1));
            im = (i < 4) ? 5'd0 : 5'($urandom_range(0, 31));
            r = 4'($urandom_range(0, 15)); ci = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = 8'($urandom_range(0, 31));
                1:       a = 8'd32;
                2:       a = 8'($urandom_range(33, 40));
                default: a = 8'($urandom_range(0, 255));
            endcase
            rfd = {24'($urandom), a};
            e = model(op, st, ur, ur ? a : {3'b000, im}, ci);
            run_op(op, st, ur, im, r, ci, rfd, res, co, lat, rdc, rda, bsy1, baft);
            chk("rnd_res", res, e[31:0]);
            chk("rnd_c", co, {31'd0, e[32]});
            chk("rnd_lat", lat, ur ? 32'd8 : 32'd6);
            chk("rnd_rdc", rdc, ur ? 32'd1 : 32'hFFFFFFFF);
            if (ur) chk("rnd_rda", rda, {28'd0, r});
        end

        // Extra start pulses in cycles 2..6 must be ignored.
        @(negedge clock);
        bus.start = 1'b1; bus.op = 32'h0000000F; bus.stype = 2'b01; bus.use_reg = 1'b0;
        bus.imm = 5'd2; bus.c_in = 1'b0;
        ndone = 0; b7 = 1'b1; res = 32'd0; co = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clock);
            if (cyc == 7) b7 = bus.busy;
            if (bus.done === 1'b1) begin ndone++; res = bus.result; co = bus.c_out; end
            bus.start = (cyc >= 1 && cyc <= 5) ? 1'b1 : 1'b0;
            bus.op = $urandom; bus.imm = 5'($urandom);
        end
        bus.start = 1'b0;
        chk("hs_ndone", ndone, 32'd1);
        chk("hs_res", res, 32'h00000003);
        chk("hs_c", co, 32'd1);
        chk("hs_busy7", b7, 32'd0);

        // Reset asserted in cycle 3 of a register-amount request.
        @(negedge clock);
        bus.start = 1'b1; bus.op = 32'h12345678; bus.stype = 2'b00; bus.use_reg = 1'b1;
        bus.rs = 4'd5; bus.c_in = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        bus.rf_data = 32'h00000004;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_busy", bus.busy, 32'd0);
        chk("rst_mid_done", bus.done, 32'd0);
        chk("rst_mid_result", bus.result, 32'd0);
        chk("rst_mid_rfrd", bus.rf_rd, 32'd0);
        reset = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clock);
            if (bus.done === 1'b1) ndone++;
        end
        chk("rst_mid_nodone", ndone, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
